mem_stage_lsu: RTL and testbench

Parametrised successor to the pipeline memory-access stage. Sits between EXE and WB and holds one instruction at a time. Issues loads and stores on a request/response memory bus with variable latency, so the stage can stall. It also does byte-lane alignment, sign/zero extension and misalignment detection, and drives EXE forwarding data with a data-valid qualifier for pending loads.

---
 rtl/mem_stage_lsu.sv | 227 ++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : mem_stage_lsu
//  Brief    : Single-entry memory-access pipeline stage with a req/resp bus,
//             byte-lane alignment, load extension and misalignment detection.
//  Revision : 1.0 - initial release
// ============================================================================
module mem_stage_lsu #(
    parameter int XLEN           = 32,
    parameter int ADDR_WIDTH     = 32,
    parameter int REG_ADDR_WIDTH = 5,
    parameter int SIDE_WIDTH     = 96
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      s_valid,
    output logic                      s_ready,
    input  logic [SIDE_WIDTH-1:0]     s_side,
    input  logic [XLEN-1:0]           s_alu_out,
    input  logic [XLEN-1:0]           s_rs2,
    input  logic [2:0]                s_mem_op,
    input  logic                      s_mem_wen,
    input  logic                      s_mem_ren,
    input  logic                      s_reg_wen,
    input  logic [REG_ADDR_WIDTH-1:0] s_reg_waddr,
    output logic                      m_valid,
    input  logic                      m_ready,
    output logic [SIDE_WIDTH-1:0]     m_side,
    output logic                      m_reg_wen,
    output logic [REG_ADDR_WIDTH-1:0] m_reg_waddr,
    output logic [XLEN-1:0]           m_alu_out,
    output logic [XLEN-1:0]           m_mem_out,
    output logic                      m_misalign,
    output logic                      fwd_wen,
    output logic [REG_ADDR_WIDTH-1:0] fwd_waddr,
    output logic [XLEN-1:0]           fwd_data,
    output logic                      fwd_data_valid,
    output logic                      mem_req_valid,
    input  logic                      mem_req_ready,
    output logic [ADDR_WIDTH-1:0]     mem_req_addr,
    output logic                      mem_req_wen,
    output logic [XLEN-1:0]           mem_req_wdata,
    output logic [XLEN/8-1:0]         mem_req_wstrb,
    input  logic                      mem_resp_valid,
    input  logic [XLEN-1:0]           mem_resp_rdata
);

    localparam int c_NB   = XLEN / 8;
    localparam int c_OFFW = $clog2(c_NB);

    localparam logic [1:0] c_IDLE  = 2'd0;
    localparam logic [1:0] c_ISSUE = 2'd1;
    localparam logic [1:0] c_WAIT  = 2'd2;
    localparam logic [1:0] c_HOLD  = 2'd3;

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;

    logic [SIDE_WIDTH-1:0]     r_side;
    logic [XLEN-1:0]           r_alu_out;
    logic [XLEN-1:0]           r_mem_out;
    logic [2:0]                r_mem_op;
    logic                      r_wen;
    logic                      r_ren;
    logic                      r_reg_wen;
    logic [REG_ADDR_WIDTH-1:0] r_reg_waddr;
    logic                      r_misalign;
    logic [XLEN-1:0]           r_req_wdata;
    logic [c_NB-1:0]           r_req_wstrb;

    logic                      w_accept;
    logic                      w_mem_any;
    logic                      w_illegal;
    logic                      w_misal;
    logic                      w_bad;
    logic                      w_to_hold;
    logic [c_OFFW-1:0]         w_off;
    logic [2:0]                w_off3;
    logic [c_NB-1:0]           w_mask;
    logic [c_NB-1:0]           w_wstrb;
    logic [XLEN-1:0]           w_wdata;
    logic [c_OFFW-1:0]         w_roff;
    logic [XLEN-1:0]           w_rsh;
    logic [XLEN-1:0]           w_ext;

    // ---------------- incoming access decode ----------------
    assign w_off     = s_alu_out[c_OFFW-1:0];
    assign w_off3    = 3'(w_off);
    assign w_mem_any = s_mem_wen | s_mem_ren;

    always_comb begin
        w_illegal = (s_mem_op == 3'b111) || (s_mem_wen && s_mem_ren) ||
                    (s_mem_wen && s_mem_op[2]) ||
                    ((XLEN == 32) && ((s_mem_op == 3'b011) || (s_mem_op == 3'b110)));
        case (s_mem_op[1:0])
            2'b01:   w_misal = w_off3[0];
            2'b10:   w_misal = (w_off3[1:0] != 2'b00);
            2'b11:   w_misal = (w_off3 != 3'b000);
            default: w_misal = 1'b0;
        endcase
    end

    // The op field is don't-care for non-memory instructions, so only mem ops can fault
    assign w_bad     = w_mem_any && (w_illegal || w_misal);
    assign w_to_hold = !w_mem_any || w_bad;
    assign w_accept  = s_valid && s_ready;

    always_comb begin
        case (s_mem_op[1:0])
            2'b00:   w_mask = c_NB'(8'h01);
            2'b01:   w_mask = c_NB'(8'h03);
            2'b10:   w_mask = c_NB'(8'h0F);
            default: w_mask = c_NB'(8'hFF);
        endcase
    end

    assign w_wstrb = s_mem_wen ? (w_mask << w_off) : '0;
    assign w_wdata = s_rs2 << {w_off, 3'b000};

    // ---------------- load data extraction ----------------
    assign w_roff = r_alu_out[c_OFFW-1:0];
    assign w_rsh  = mem_resp_rdata >> {w_roff, 3'b000};

    always_comb begin
        case (r_mem_op)
            3'b000:  w_ext = XLEN'($signed(w_rsh[7:0]));
            3'b001:  w_ext = XLEN'($signed(w_rsh[15:0]));
            3'b010:  w_ext = XLEN'($signed(w_rsh[31:0]));
            3'b100:  w_ext = XLEN'(w_rsh[7:0]);
            3'b101:  w_ext = XLEN'(w_rsh[15:0]);
            3'b110:  w_ext = XLEN'(w_rsh[31:0]);
            default: w_ext = w_rsh;
        endcase
    end

    // ---------------- FSM: state register ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= c_IDLE;
        else      r_state <= w_next_state;
    end

    // ---------------- FSM: next state ----------------
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            c_IDLE:  if (s_valid)        w_next_state = w_to_hold ? c_HOLD : c_ISSUE;
            c_ISSUE: if (mem_req_ready)  w_next_state = c_WAIT;
            c_WAIT:  if (mem_resp_valid) w_next_state = c_HOLD;
            c_HOLD: begin
                if (m_ready) w_next_state = s_valid ? (w_to_hold ? c_HOLD : c_ISSUE) : c_IDLE;
            end
            default: w_next_state = c_IDLE;
        endcase
    end

    // ---------------- FSM: outputs ----------------
    // fwd_data_valid is held low in IDLE so every output is quiet out of reset
    always_comb begin
        s_ready        = 1'b0;
        m_valid        = 1'b0;
        mem_req_valid  = 1'b0;
        fwd_data_valid = 1'b0;
        case (r_state)
            c_IDLE:  s_ready = 1'b1;
            c_ISSUE: begin
                mem_req_valid  = 1'b1;
                fwd_data_valid = !r_ren;
            end
            c_WAIT:  fwd_data_valid = !r_ren;
            c_HOLD: begin
                s_ready        = m_ready;
                m_valid        = 1'b1;
                fwd_data_valid = 1'b1;
            end
            default: s_ready = 1'b0;
        endcase
    end

    // ---------------- payload registers ----------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_side      <= '0;
            r_alu_out   <= '0;
            r_mem_out   <= '0;
            r_mem_op    <= '0;
            r_wen       <= 1'b0;
            r_ren       <= 1'b0;
            r_reg_wen   <= 1'b0;
            r_reg_waddr <= '0;
            r_misalign  <= 1'b0;
            r_req_wdata <= '0;
            r_req_wstrb <= '0;
        end else if (w_accept) begin
            r_side      <= s_side;
            r_alu_out   <= s_alu_out;
            r_mem_out   <= '0;
            r_mem_op    <= s_mem_op;
            r_wen       <= s_mem_wen;
            r_ren       <= s_mem_ren;
            r_reg_wen   <= s_reg_wen;
            r_reg_waddr <= s_reg_waddr;
            r_misalign  <= w_bad;
            r_req_wdata <= w_wdata;
            r_req_wstrb <= w_wstrb;
        end else if ((r_state == c_WAIT) && mem_resp_valid && r_ren) begin
            r_mem_out   <= w_ext;
        end
    end

    assign m_side        = r_side;
    assign m_reg_wen     = r_reg_wen && !r_misalign;
    assign m_reg_waddr   = r_reg_waddr;
    assign m_alu_out     = r_alu_out;
    assign m_mem_out     = r_mem_out;
    assign m_misalign    = r_misalign;

    assign fwd_wen       = (r_state != c_IDLE) && r_reg_wen && !r_misalign;
    assign fwd_waddr     = r_reg_waddr;
    assign fwd_data      = r_ren ? r_mem_out : r_alu_out;

    assign mem_req_addr  = r_alu_out[ADDR_WIDTH-1:0];
    assign mem_req_wen   = r_wen;
    assign mem_req_wdata = r_req_wdata;
    assign mem_req_wstrb = r_req_wstrb;

endmodule
`default_nettype wire

// File: tb/tb_mem_stage_lsu.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_stage_lsu
//  Brief    : Directed self-checking bench for mem_stage_lsu.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_mem_stage_lsu;

    logic        clk;
    logic        rst;
    logic        s_valid, s_ready;
    logic [95:0] s_side;
    logic [31:0] s_alu_out, s_rs2;
    logic [2:0]  s_mem_op;
    logic        s_mem_wen, s_mem_ren, s_reg_wen;
    logic [4:0]  s_reg_waddr;
    logic        m_valid, m_ready;
    logic [95:0] m_side;
    logic        m_reg_wen;
    logic [4:0]  m_reg_waddr;
    logic [31:0] m_alu_out, m_mem_out;
    logic        m_misalign;
    logic        fwd_wen;
    logic [4:0]  fwd_waddr;
    logic [31:0] fwd_data;
    logic        fwd_data_valid;
    logic        mem_req_valid, mem_req_ready;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_resp_valid;
    logic [31:0] mem_resp_rdata;

    int checks = 0;
    int errors = 0;

    mem_stage_lsu dut (
        .clk(clk), .rst(rst),
        .s_valid(s_valid), .s_ready(s_ready), .s_side(s_side),
        .s_alu_out(s_alu_out), .s_rs2(s_rs2), .s_mem_op(s_mem_op),
        .s_mem_wen(s_mem_wen), .s_mem_ren(s_mem_ren),
        .s_reg_wen(s_reg_wen), .s_reg_waddr(s_reg_waddr),
        .m_valid(m_valid), .m_ready(m_ready), .m_side(m_side),
        .m_reg_wen(m_reg_wen), .m_reg_waddr(m_reg_waddr),
        .m_alu_out(m_alu_out), .m_mem_out(m_mem_out), .m_misalign(m_misalign),
        .fwd_wen(fwd_wen), .fwd_waddr(fwd_waddr), .fwd_data(fwd_data),
        .fwd_data_valid(fwd_data_valid),
        .mem_req_valid(mem_req_valid), .mem_req_ready(mem_req_ready),
        .mem_req_addr(mem_req_addr), .mem_req_wen(mem_req_wen),
        .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb),
        .mem_resp_valid(mem_resp_valid), .mem_resp_rdata(mem_resp_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    task automatic drive(input logic [31:0] addr, input logic [2:0] op,
                         input logic wen, input logic ren,
                         input logic rwen, input logic [4:0] rd,
                         input logic [31:0] rs2);
        s_valid = 1'b1; s_alu_out = addr; s_mem_op = op;
        s_mem_wen = wen; s_mem_ren = ren; s_reg_wen = rwen;
        s_reg_waddr = rd; s_rs2 = rs2;
    endtask

    task automatic test_reset;
        rst = 1'b1; s_valid = 0; s_side = '0; s_alu_out = '0; s_rs2 = '0;
        s_mem_op = '0; s_mem_wen = 0; s_mem_ren = 0; s_reg_wen = 0; s_reg_waddr = '0;
        m_ready = 0; mem_req_ready = 0; mem_resp_valid = 0; mem_resp_rdata = '0;
        #1 rst = 1'b0;
        #2;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL reset_s_ready: got %b want 1", s_ready);
        end
        checks++;
        if ({m_valid, mem_req_valid, fwd_wen, fwd_data_valid, m_misalign, m_reg_wen, mem_req_wen} !== 7'b0) begin
            errors++; $display("FAIL reset_flags: got %b want 0000000",
                {m_valid, mem_req_valid, fwd_wen, fwd_data_valid, m_misalign, m_reg_wen, mem_req_wen});
        end
        checks++;
        if ({m_alu_out, m_mem_out, fwd_data, mem_req_wdata, mem_req_addr, mem_req_wstrb} !== 164'h0 || m_side !== 96'h0) begin
            errors++; $display("FAIL reset_data: alu=%h mem=%h fwd=%h side=%h want 0",
                m_alu_out, m_mem_out, fwd_data, m_side);
        end
        repeat (2) @(negedge clk);
        rst = 1'b1;
    endtask

    task automatic test_alu;
        @(negedge clk);
        s_side = 96'h0123_4567_89AB_CDEF_0011_2233;
        drive(32'h1234, 3'b010, 0, 0, 1, 5'd5, 32'h0);
        m_ready = 1;
        @(negedge clk);
        s_valid = 0;
        checks++;
        if ({m_valid, mem_req_valid, fwd_wen, fwd_data_valid, m_reg_wen, m_misalign} !== 6'b101110) begin
            errors++; $display("FAIL alu_flags: got %b want 101110",
                {m_valid, mem_req_valid, fwd_wen, fwd_data_valid, m_reg_wen, m_misalign});
        end
        checks++;
        if (m_alu_out !== 32'h1234 || fwd_data !== 32'h1234 || m_mem_out !== 32'h0) begin
            errors++; $display("FAIL alu_data: alu=%h fwd=%h mem=%h want 1234/1234/0",
                m_alu_out, fwd_data, m_mem_out);
        end
        checks++;
        if (fwd_waddr !== 5'd5 || m_reg_waddr !== 5'd5 || m_side !== 96'h0123_4567_89AB_CDEF_0011_2233) begin
            errors++; $display("FAIL alu_rd_side: fwd_waddr=%0d rd=%0d side=%h want 5/5/0123..2233",
                fwd_waddr, m_reg_waddr, m_side);
        end
        @(negedge clk);
        checks++;
        if ({m_valid, s_ready, fwd_wen} !== 3'b010) begin
            errors++; $display("FAIL alu_drain: got %b want 010", {m_valid, s_ready, fwd_wen});
        end
    endtask

    task automatic test_load;
        logic [2:0]  ops  [2] = '{3'b000, 3'b100};
        logic [31:0] exps [2] = '{32'hFFFF_FF80, 32'h0000_0080};
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            drive(32'h1003, ops[i], 0, 1, 1, 5'd7, 32'hDEAD_BEEF);
            m_ready = 1;
            @(negedge clk);
            s_valid = 0;
            checks++;
            if ({mem_req_valid, mem_req_wen, mem_req_wstrb, fwd_data_valid, fwd_wen, m_valid, s_ready} !== 10'b10_0000_0100 ||
                mem_req_addr !== 32'h1003) begin
                errors++; $display("FAIL load_issue[%0d]: v=%b wen=%b strb=%b fdv=%b addr=%h want 1/0/0000/0/1003",
                    i, mem_req_valid, mem_req_wen, mem_req_wstrb, fwd_data_valid, mem_req_addr);
            end
            mem_req_ready = 1;
            @(negedge clk);
            mem_req_ready = 0;
            checks++;
            if ({mem_req_valid, fwd_data_valid, m_valid} !== 3'b000) begin
                errors++; $display("FAIL load_wait[%0d]: got %b want 000",
                    i, {mem_req_valid, fwd_data_valid, m_valid});
            end
            @(negedge clk);
            mem_resp_valid = 1; mem_resp_rdata = 32'h80AA_BBCC;
            @(negedge clk);
            mem_resp_valid = 0;
            checks++;
            if (m_valid !== 1'b1 || m_mem_out !== exps[i] || fwd_data !== exps[i] ||
                fwd_data_valid !== 1'b1 || m_misalign !== 1'b0 || m_reg_wen !== 1'b1) begin
                errors++; $display("FAIL load_result[%0d]: mv=%b mem=%h fwd=%h fdv=%b want 1/%h/%h/1",
                    i, m_valid, m_mem_out, fwd_data, fwd_data_valid, exps[i], exps[i]);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_store;
        @(negedge clk);
        drive(32'h2002, 3'b001, 1, 0, 0, 5'd0, 32'h0000_BEEF);
        m_ready = 1; mem_req_ready = 0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            s_valid = 0; s_rs2 = $urandom; s_alu_out = $urandom;
            checks++;
            if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h2002 || mem_req_wstrb !== 4'b1100 ||
                mem_req_wdata !== 32'hBEEF_0000 || mem_req_wen !== 1'b1) begin
                errors++; $display("FAIL store_req[%0d]: v=%b addr=%h strb=%b wdata=%h wen=%b want 1/2002/1100/beef0000/1",
                    i, mem_req_valid, mem_req_addr, mem_req_wstrb, mem_req_wdata, mem_req_wen);
            end
        end
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        checks++;
        if ({mem_req_valid, m_valid} !== 2'b00) begin
            errors++; $display("FAIL store_wait: got %b want 00", {mem_req_valid, m_valid});
        end
        mem_resp_valid = 1; mem_resp_rdata = 32'hFFFF_FFFF;
        @(negedge clk);
        mem_resp_valid = 0;
        checks++;
        if ({m_valid, fwd_wen, m_misalign, m_reg_wen} !== 4'b1000 || m_mem_out !== 32'h0 || fwd_data !== 32'h2002) begin
            errors++; $display("FAIL store_done: flags=%b mem=%h fwd=%h want 1000/0/2002",
                {m_valid, fwd_wen, m_misalign, m_reg_wen}, m_mem_out, fwd_data);
        end
        @(negedge clk);
    endtask

    task automatic test_misalign;
        logic [31:0] addrs [4] = '{32'h3001, 32'h3000, 32'h3000, 32'h3004};
        logic [2:0]  ops   [4] = '{3'b010, 3'b100, 3'b011, 3'b000};
        logic        wens  [4] = '{1'b0, 1'b1, 1'b0, 1'b1};
        logic        rens  [4] = '{1'b1, 1'b0, 1'b1, 1'b1};
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            drive(addrs[i], ops[i], wens[i], rens[i], 1, 5'd9, 32'h1111_2222);
            m_ready = 1; mem_req_ready = 1;
            @(negedge clk);
            s_valid = 0;
            checks++;
            if ({mem_req_valid, m_valid, m_misalign, m_reg_wen, fwd_wen} !== 5'b01100 || m_mem_out !== 32'h0) begin
                errors++; $display("FAIL misalign[%0d]: req/mv/mis/rwen/fwen=%b mem=%h want 01100/0",
                    i, {mem_req_valid, m_valid, m_misalign, m_reg_wen, fwd_wen}, m_mem_out);
            end
            mem_req_ready = 0;
            @(negedge clk);
        end
    endtask

    task automatic test_back_to_back;
        @(negedge clk);
        m_ready = 0;
        drive(32'h10, 3'b010, 0, 1, 1, 5'd3, 32'h0);
        @(negedge clk);
        s_valid = 0;
        checks++;
        if (mem_req_valid !== 1'b1 || mem_req_addr !== 32'h10) begin
            errors++; $display("FAIL b2b_issue_a: v=%b addr=%h want 1/10", mem_req_valid, mem_req_addr);
        end
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h1122_3344;
        @(negedge clk);
        mem_resp_valid = 0;
        drive(32'h22, 3'b001, 0, 1, 1, 5'd4, 32'h0);
        for (int i = 0; i < 3; i++) begin
            checks++;
            if ({s_ready, m_valid} !== 2'b01 || m_mem_out !== 32'h1122_3344 ||
                m_reg_waddr !== 5'd3 || fwd_waddr !== 5'd3) begin
                errors++; $display("FAIL b2b_hold[%0d]: sr/mv=%b mem=%h rd=%0d want 01/11223344/3",
                    i, {s_ready, m_valid}, m_mem_out, m_reg_waddr);
            end
            if (i < 2) @(negedge clk);
        end
        m_ready = 1;
        #1;
        checks++;
        if (s_ready !== 1'b1) begin
            errors++; $display("FAIL b2b_ready: got %b want 1", s_ready);
        end
        @(negedge clk);
        s_valid = 0;
        checks++;
        if ({m_valid, mem_req_valid, fwd_data_valid} !== 3'b010 || mem_req_addr !== 32'h22 || fwd_waddr !== 5'd4) begin
            errors++; $display("FAIL b2b_issue_b: mv/req/fdv=%b addr=%h rd=%0d want 010/22/4",
                {m_valid, mem_req_valid, fwd_data_valid}, mem_req_addr, fwd_waddr);
        end
        mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0; mem_resp_valid = 1; mem_resp_rdata = 32'h8001_0000;
        @(negedge clk);
        mem_resp_valid = 0;
        checks++;
        if (m_valid !== 1'b1 || m_mem_out !== 32'hFFFF_8001 || m_reg_waddr !== 5'd4) begin
            errors++; $display("FAIL b2b_result_b: mv=%b mem=%h rd=%0d want 1/ffff8001/4",
                m_valid, m_mem_out, m_reg_waddr);
        end
        @(negedge clk);
    endtask

    task automatic test_reset_midflight;
        @(negedge clk);
        drive(32'h40, 3'b010, 0, 1, 1, 5'd6, 32'h0);
        m_ready = 1;
        @(negedge clk);
        s_valid = 0; mem_req_ready = 1;
        @(negedge clk);
        mem_req_ready = 0;
        checks++;
        if ({s_ready, mem_req_valid, fwd_data_valid} !== 3'b000) begin
            errors++; $display("FAIL rstmid_wait: got %b want 000", {s_ready, mem_req_valid, fwd_data_valid});
        end
        #2 rst = 1'b0;
        #1;
        checks++;
        if ({s_ready, m_valid, mem_req_valid, fwd_wen} !== 4'b1000 || m_alu_out !== 32'h0) begin
            errors++; $display("FAIL rstmid_async: sr/mv/req/fwen=%b alu=%h want 1000/0",
                {s_ready, m_valid, mem_req_valid, fwd_wen}, m_alu_out);
        end
        @(negedge clk);
        rst = 1'b1; mem_resp_valid = 1; mem_resp_rdata = 32'hCAFE_F00D;
        @(negedge clk);
        mem_resp_valid = 0;
        checks++;
        if ({s_ready, m_valid, fwd_data_valid} !== 3'b100 || m_mem_out !== 32'h0) begin
            errors++; $display("FAIL rstmid_late_resp: sr/mv/fdv=%b mem=%h want 100/0",
                {s_ready, m_valid, fwd_data_valid}, m_mem_out);
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_load();
        test_store();
        test_misalign();
        test_back_to_back();
        test_reset_midflight();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
